// File: rtl/fifo_entrada.sv
// fifo_entrada: synchronous input FIFO feeding the arbiter stage.
// Occupancy is tracked by a registered counter. All status flags are decoded
// from that counter, so they change on the same edge as the count.
// Optional feature: define FIFO_ERR_EN to build the sticky overflow/underflow
// flag on `error`. Without it, `error` is tied low and no error logic exists.
module fifo_entrada #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  fifo_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_fifo_out;
  logic                  r_fifo_valid;

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // A write is accepted while full only when a pop frees a slot on the same
  // edge. A pop is never accepted while empty, so there is no fall-through.
  assign w_wr_en = push && (!w_full || pop);
  assign w_rd_en = pop && !w_empty;

  // Storage array. Contents are not reset; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (reset && w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy counter. The pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port. fifo_out holds its last word when no read occurs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fifo_out   <= '0;
      r_fifo_valid <= 1'b0;
    end else begin
      r_fifo_valid <= w_rd_en;
      if (w_rd_en) r_fifo_out <= r_mem[r_rd_ptr];
    end
  end

`ifdef FIFO_ERR_EN
  logic r_error;

  // Sticky error: overflow (push while full, no pop) or underflow (pop while empty).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if ((push && w_full && !pop) || (pop && w_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign fifo_out     = r_fifo_out;
  assign fifo_valid   = r_fifo_valid;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);

endmodule
